pipe_backbone: RTL
==================

// Module: pipe_backbone
// PURPOSE
//  Parametrised pipeline backbone for the OpenMIPS core: PC/fetch-enable register plus NSTAGE inter-stage registers.
//  Replaces the fixed pc_reg/if_id/id_ex/ex_mem/mem_wb chain with one generalised block.
//  Adds per-stage stall with bubble insertion, global flush, PC redirect, per-stage valid bits and a stall counter.
//  Sits between the ROM interface and the combinational stages (id, ex, mem); stage logic feeds stg_d_i, reads stg_q_o.
// PARAMETERS
//  NSTAGE     4      number of inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB)
//  W          64     payload width of each inter-stage register
//  AW         32     PC width
//  RESET_VEC  0      PC value while fetch disabled / after reset (AW bits)
//  PC_STEP    4      PC increment per fetch
// PORTS
//  clk            in   1           clock, all state updates on rising edge
//  rst            in   1           asynchronous, active-high reset
//  stallreq_i     in   NSTAGE+1    stall request; bit0 = fetch, bit k = stage k (k=1..NSTAGE)
//  flush_i        in   1           clear every inter-stage register
//  redirect_i     in   1           load PC from redirect_pc_i (branch/exception)
//  redirect_pc_i  in   AW          redirect target
//  stg_d_i        in   NSTAGE*W    slice k = stage-k result, captured by register k
//  stg_q_o        out  NSTAGE*W    slice k = register k contents, drives stage k+1
//  stg_vld_o      out  NSTAGE      bit k = register k holds a real instruction
//  pc_o           out  AW          fetch address (to rom_addr_o)
//  ce_o           out  1           fetch enable (to rom_ce_o)
//  stall_o        out  NSTAGE+1    resolved stall vector
//  stall_cnt_o    out  16          cycles with fetch stalled
// BEHAVIOUR
//  Reset (async, immediate on rst=1): ce_o=0, pc_o=RESET_VEC, stg_q_o=0, stg_vld_o=0, stall_cnt_o=0.
//  stall_o combinational: stall[k] = OR(stallreq_i[NSTAGE:k]); a request stalls its stage and all upstream.
//  ce_o: 0 during reset; 1 from first rising edge with rst=0; stays 1 until next reset.
//  PC, per edge, priority order:
//   - ce_o=0: pc_o = RESET_VEC (redirect ignored)
//   - redirect_i=1: pc_o = redirect_pc_i, overrides stall[0]
//   - stall[0]=1: hold
//   - else pc_o = pc_o + PC_STEP, modulo 2^AW (wraps silently)
//  Register k (k=0..NSTAGE-1), stall[NSTAGE] = stallreq_i[NSTAGE], per edge, priority order:
//   - flush_i=1: q=0, vld=0 (overrides stall)
//   - stall[k]=1 and stall[k+1]=0: bubble, q=0, vld=0
//   - stall[k]=1 and stall[k+1]=1: hold q and vld
//   - else load: q = stg_d_i slice k; vld = ce_o (k=0) or stg_vld_o[k-1] (k>0)
//  Latency: one cycle per register; fetch-to-register-k = k+1 edges with no stalls.
//  flush_i with redirect_i same cycle: both apply; next cycle pc_o = target, all vld = 0.
//  stall_cnt_o: +1 on each edge with ce_o=1 and stall[0]=1; saturates at 16'hFFFF; cleared only by rst.
//  Reset asserted mid-stall/flush: all state clears asynchronously, no partial update on the next edge.
//  No X on outputs after reset regardless of stg_d_i contents.
// TESTING
//  Reset release, no stalls: edge1 ce_o=1, pc_o=0; then pc_o 4,8,12; stg_vld_o 0001,0011,0111,1111.
//  stallreq_i=5'b00100 held 2 cycles: stall_o=00111; pc_o and regs 0,1 hold; reg2 q=0,vld=0; reg3 loads; stall_cnt_o+=2.
//  flush_i=1, redirect_i=1, redirect_pc_i=0x80 while full: next edge stg_q_o=0, stg_vld_o=0000, pc_o=0x80, then 0x84.
//  redirect_i=1 (0x200) with stallreq_i[0]=1: pc_o=0x200 next edge; following stalled edge pc_o holds 0x200.
//  AW=8, RESET_VEC=8'hF8, PC_STEP=4: pc_o F8,FC,00,04 (wrap); stall 70000 cycles: stall_cnt_o sticks at FFFF.
//  rst=1 between edges during a stall: pc_o, stg_q_o, stg_vld_o, ce_o, stall_cnt_o zero/RESET_VEC before next edge.

Source files
------------

// File: rtl/pipe_backbone_if.sv
// Bundle between the pipeline backbone and the stage logic / fetch port.
// The master side is the core around the backbone; the slave side is the backbone itself.
interface pipe_backbone_if #(
  parameter int NSTAGE = 4,
  parameter int W      = 64,
  parameter int AW     = 32
);
  logic [NSTAGE:0]   stallreq_i;
  logic              flush_i;
  logic              redirect_i;
  logic [AW-1:0]     redirect_pc_i;
  logic [NSTAGE*W-1:0] stg_d_i;
  logic [NSTAGE*W-1:0] stg_q_o;
  logic [NSTAGE-1:0] stg_vld_o;
  logic [AW-1:0]     pc_o;
  logic              ce_o;
  logic [NSTAGE:0]   stall_o;
  logic [15:0]       stall_cnt_o;

  modport master (
    output stallreq_i, flush_i, redirect_i, redirect_pc_i, stg_d_i,
    input  stg_q_o, stg_vld_o, pc_o, ce_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  stallreq_i, flush_i, redirect_i, redirect_pc_i, stg_d_i,
    output stg_q_o, stg_vld_o, pc_o, ce_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_backbone.sv
// Generalised OpenMIPS pipeline backbone: PC/fetch-enable register plus NSTAGE
// inter-stage registers with stall/bubble, flush, redirect and a fetch-stall counter.
module pipe_backbone #(
  parameter int            NSTAGE    = 4,
  parameter int            W         = 64,
  parameter int            AW        = 32,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter logic [AW-1:0] PC_STEP   = AW'(4)
) (
  input logic               clk,
  input logic               rst,
  pipe_backbone_if.slave    bus
);

  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] pc);
    return pc + PC_STEP;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [NSTAGE:0]   stall;
  logic              ce_p0;
  logic [AW-1:0]     pc_p0;
  logic [15:0]       stall_cnt;
  logic [NSTAGE-1:0] vld_all;

  // A request at stage k also stalls everything upstream of it.
  always_comb begin
    stall = '0;
    stall[NSTAGE] = bus.stallreq_i[NSTAGE];
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      stall[k] = stall[k+1] | bus.stallreq_i[k];
    end
  end

  // Fetch stage: enable, PC and stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_p0     <= 1'b0;
      pc_p0     <= RESET_VEC;
      stall_cnt <= 16'd0;
    end else begin
      ce_p0 <= 1'b1;
      if (!ce_p0)
        pc_p0 <= RESET_VEC;
      else if (bus.redirect_i)
        pc_p0 <= bus.redirect_pc_i;
      else if (!stall[0])
        pc_p0 <= pc_inc(pc_p0);
      if (ce_p0 && stall[0])
        stall_cnt <= sat_inc16(stall_cnt);
    end
  end

  // Inter-stage registers: register k sits between stage k and stage k+1
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
    logic [W-1:0] q_pk;
    logic         vld_pk;
    logic         vld_src;

    if (k == 0) begin : g_src_fetch
      assign vld_src = ce_p0;
    end else begin : g_src_prev
      assign vld_src = vld_all[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_pk   <= '0;
        vld_pk <= 1'b0;
      end else if (bus.flush_i || (stall[k] && !stall[k+1])) begin
        q_pk   <= '0;
        vld_pk <= 1'b0;
      end else if (!stall[k]) begin
        q_pk   <= bus.stg_d_i[k*W +: W];
        vld_pk <= vld_src;
      end
    end

    assign vld_all[k]            = vld_pk;
    assign bus.stg_q_o[k*W +: W] = q_pk;
  end

  assign bus.stg_vld_o   = vld_all;
  assign bus.pc_o        = pc_p0;
  assign bus.ce_o        = ce_p0;
  assign bus.stall_o     = stall;
  assign bus.stall_cnt_o = stall_cnt;

endmodule
